// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared constants for the write-back port arbiter.
// Holds the default widths, the requester count and index constants, the
// zero-data constant and a one-hot to index helper.
package wb_port_arbiter_pkg;

   localparam int unsigned PREG_W_DEF = 7;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int          REQ_N      = 4;

   // Requester indices inside ReqValid/ReqAddr/ReqDate
   localparam logic [1:0] DIV  = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] CSRU = 2'd2;
   localparam logic [1:0] LSU  = 2'd3;

   localparam logic [DATA_W_DEF-1:0] ZERO_DATA = {DATA_W_DEF{1'b0}};

   // Convert a one-hot (or all-zero) grant vector to a requester index
   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] idx_v;
      idx_v = 2'd0;
      for (int i = 0; i < REQ_N; i++) begin
         if (oh[i]) begin
            idx_v = 2'(i);
         end else begin
            idx_v = idx_v;
         end
      end
      return idx_v;
   endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// wb_rr_pick2: combinational rotate-scan picking up to two requesters.
// The first valid requester from ptr onwards goes to port 0; the next valid
// requester whose destination differs from port 0's goes to port 1.
module wb_rr_pick2
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned PREG_W = PREG_W_DEF
)(
   input  logic [3:0]          valid,
   input  logic [4*PREG_W-1:0] addr,
   input  logic [1:0]          ptr,
   output logic [3:0]          gnt0,
   output logic [3:0]          gnt1,
   output logic [1:0]          last_idx
);

   logic [PREG_W-1:0] addr_a [REQ_N];

   // Unpack per-requester destination register indices
   always_comb begin
      for (int i = 0; i < REQ_N; i++) begin
         addr_a[i] = addr[i*PREG_W +: PREG_W];
      end
   end

   // Rotating scan with destination-conflict skip for the second grant
   always_comb begin
      logic [1:0]        idx_v;
      logic [PREG_W-1:0] addr0_v;
      logic              found0_v;
      logic              found1_v;
      gnt0     = 4'b0000;
      gnt1     = 4'b0000;
      last_idx = ptr;
      idx_v    = ptr;
      addr0_v  = {PREG_W{1'b0}};
      found0_v = 1'b0;
      found1_v = 1'b0;
      for (int k = 0; k < REQ_N; k++) begin
         idx_v = ptr + 2'(k);
         if (valid[idx_v]) begin
            if (!found0_v) begin
               found0_v    = 1'b1;
               gnt0[idx_v] = 1'b1;
               addr0_v     = addr_a[idx_v];
               last_idx    = idx_v;
            end else if (!found1_v && (addr_a[idx_v] != addr0_v)) begin
               found1_v    = 1'b1;
               gnt1[idx_v] = 1'b1;
               last_idx    = idx_v;
            end else begin
               found1_v = found1_v;
            end
         end else begin
            found0_v = found0_v;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates four result producers (Div, Mul, Csru, Lsu)
// onto two registered physical-register-file write ports.
// Define WB_ARB_RR_EN for rotating priority; otherwise priority is fixed
// Div > Mul > Csru > Lsu (scan pointer tied to 0).
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned PREG_W = PREG_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
)(
   input  logic                Clk,
   input  logic                Rest,
   input  logic                ArbStop,
   input  logic                ArbFlash,
   input  logic [3:0]          ReqValid,
   input  logic [4*PREG_W-1:0] ReqAddr,
   input  logic [4*DATA_W-1:0] ReqDate,
   output logic [3:0]          ReqReady,
   output logic                WbPort0Able,
   output logic [PREG_W-1:0]   WbPort0Addr,
   output logic [DATA_W-1:0]   WbPort0Date,
   output logic                WbPort1Able,
   output logic [PREG_W-1:0]   WbPort1Addr,
   output logic [DATA_W-1:0]   WbPort1Date
);

   logic [1:0]        ptr_s;
   logic [3:0]        gnt0_s;
   logic [3:0]        gnt1_s;
   logic [1:0]        last_s;
   logic [1:0]        idx0_s;
   logic [1:0]        idx1_s;
   logic              open_s;
   logic [PREG_W-1:0] req_addr_a [REQ_N];
   logic [DATA_W-1:0] req_data_a [REQ_N];

   wb_rr_pick2 #(.PREG_W(PREG_W)) u_pick (
      .valid    (ReqValid),
      .addr     (ReqAddr),
      .ptr      (ptr_s),
      .gnt0     (gnt0_s),
      .gnt1     (gnt1_s),
      .last_idx (last_s)
   );

   // Arbitration is only open out of reset and with no stall or flush
   assign open_s = Rest & ~ArbStop & ~ArbFlash;
   assign idx0_s = oh2idx(gnt0_s);
   assign idx1_s = oh2idx(gnt1_s);

   // Unpack per-requester address and data buses
   always_comb begin
      for (int i = 0; i < REQ_N; i++) begin
         req_addr_a[i] = ReqAddr[i*PREG_W +: PREG_W];
         req_data_a[i] = ReqDate[i*DATA_W +: DATA_W];
      end
   end

   // Grants reach the requesters only when the pipeline can take them
   always_comb begin
      if (open_s) begin
         ReqReady = gnt0_s | gnt1_s;
      end else begin
         ReqReady = 4'b0000;
      end
   end

`ifdef WB_ARB_RR_EN
   logic [1:0] ptr_r;

   // Scan pointer moves just past the last granted requester; flush rewinds it
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         ptr_r <= 2'd0;
      end else if (ArbFlash) begin
         ptr_r <= 2'd0;
      end else if (ArbStop) begin
         ptr_r <= ptr_r;
      end else if (|gnt0_s) begin
         ptr_r <= last_s + 2'd1;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr_s = ptr_r;
`else
   logic unused_last_s;

   assign ptr_s         = 2'd0;
   assign unused_last_s = ^last_s;
`endif

   // Write-port registers: capture granted results, hold under stall, drop on flush
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         WbPort0Able <= 1'b0;
         WbPort0Addr <= {PREG_W{1'b0}};
         WbPort0Date <= DATA_W'(ZERO_DATA);
         WbPort1Able <= 1'b0;
         WbPort1Addr <= {PREG_W{1'b0}};
         WbPort1Date <= DATA_W'(ZERO_DATA);
      end else if (ArbFlash) begin
         WbPort0Able <= 1'b0;
         WbPort1Able <= 1'b0;
      end else if (ArbStop) begin
         WbPort0Able <= WbPort0Able;
         WbPort1Able <= WbPort1Able;
      end else begin
         WbPort0Able <= |gnt0_s;
         WbPort1Able <= |gnt1_s;
         if (|gnt0_s) begin
            WbPort0Addr <= req_addr_a[idx0_s];
            WbPort0Date <= req_data_a[idx0_s];
         end else begin
            WbPort0Addr <= WbPort0Addr;
         end
         if (|gnt1_s) begin
            WbPort1Addr <= req_addr_a[idx1_s];
            WbPort1Date <= req_data_a[idx1_s];
         end else begin
            WbPort1Addr <= WbPort1Addr;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus a short pseudo-random run,
// checked every falling edge against a queue-based behavioural model.
module tb_wb_port_arbiter;

   localparam int PW = 7;
   localparam int DW = 32;
`ifdef WB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          Clk      = 1'b0;
   logic          Rest     = 1'b1;
   logic          ArbStop  = 1'b0;
   logic          ArbFlash = 1'b0;
   logic [3:0]    ReqValid = 4'b0000;
   logic [4*PW-1:0] ReqAddr = '0;
   logic [4*DW-1:0] ReqDate = '0;
   logic [3:0]    ReqReady;
   logic          WbPort0Able, WbPort1Able;
   logic [PW-1:0] WbPort0Addr, WbPort1Addr;
   logic [DW-1:0] WbPort0Date, WbPort1Date;

   int total = 0;
   int bad   = 0;

   // model state: what the write ports must show after the coming rising edge
   int          m_ptr = 0;
   logic        m_able0 = 1'b0, m_able1 = 1'b0;
   logic [PW-1:0] m_addr0 = '0, m_addr1 = '0;
   logic [DW-1:0] m_data0 = '0, m_data1 = '0;

   wb_port_arbiter #(.PREG_W(PW), .DATA_W(DW)) dut (
      .Clk(Clk), .Rest(Rest), .ArbStop(ArbStop), .ArbFlash(ArbFlash),
      .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqDate(ReqDate), .ReqReady(ReqReady),
      .WbPort0Able(WbPort0Able), .WbPort0Addr(WbPort0Addr), .WbPort0Date(WbPort0Date),
      .WbPort1Able(WbPort1Able), .WbPort1Addr(WbPort1Addr), .WbPort1Date(WbPort1Date)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] a_of(input int r);
      return ReqAddr[r*PW +: PW];
   endfunction

   function automatic logic [DW-1:0] d_of(input int r);
      return ReqDate[r*DW +: DW];
   endfunction

   task automatic set_req(input int r, input logic [PW-1:0] a, input logic [DW-1:0] d);
      ReqAddr[r*PW +: PW] = a;
      ReqDate[r*DW +: DW] = d;
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   // compare process: outputs against the model, then advance the model
   always @(negedge Clk) begin
      int q[$];
      int f, s;
      logic [3:0] exp_rdy;
      if (!Rest) begin
         m_ptr = 0; m_able0 = 1'b0; m_able1 = 1'b0;
         m_addr0 = '0; m_addr1 = '0; m_data0 = '0; m_data1 = '0;
      end
      chk("m_p0_able", 64'(WbPort0Able), 64'(m_able0));
      chk("m_p0_addr", 64'(WbPort0Addr), 64'(m_addr0));
      chk("m_p0_data", 64'(WbPort0Date), 64'(m_data0));
      chk("m_p1_able", 64'(WbPort1Able), 64'(m_able1));
      chk("m_p1_addr", 64'(WbPort1Addr), 64'(m_addr1));
      chk("m_p1_data", 64'(WbPort1Date), 64'(m_data1));
      q.delete();
      f = -1;
      s = -1;
      for (int k = 0; k < 4; k++) begin
         if (ReqValid[(m_ptr + k) % 4]) q.push_back((m_ptr + k) % 4);
      end
      if (q.size() > 0) f = q[0];
      for (int j = 1; j < q.size(); j++) begin
         if (s < 0 && a_of(q[j]) != a_of(f)) s = q[j];
      end
      exp_rdy = 4'b0000;
      if (Rest && !ArbStop && !ArbFlash) begin
         if (f >= 0) exp_rdy[f] = 1'b1;
         if (s >= 0) exp_rdy[s] = 1'b1;
      end
      chk("m_ready", 64'(ReqReady), 64'(exp_rdy));
      if (Rest) begin
         if (ArbFlash) begin
            m_able0 = 1'b0; m_able1 = 1'b0; m_ptr = 0;
         end else if (!ArbStop) begin
            m_able0 = (f >= 0);
            m_able1 = (s >= 0);
            if (f >= 0) begin m_addr0 = a_of(f); m_data0 = d_of(f); end
            if (s >= 0) begin m_addr1 = a_of(s); m_data1 = d_of(s); end
            if (f >= 0 && RR) m_ptr = (((s >= 0) ? s : f) + 1) % 4;
         end
      end
   end

   initial begin
      // reset with every requester asserting
      set_req(0, 7'd40, 32'h1000_0040);
      set_req(1, 7'd41, 32'h1000_0041);
      set_req(2, 7'd42, 32'h1000_0042);
      set_req(3, 7'd43, 32'h1000_0043);
      ReqValid = 4'b1111;
      #2 Rest = 1'b0;
      cyc(); cyc();
      chk("rst_ready", 64'(ReqReady), 64'h0);
      chk("rst_p0_able", 64'(WbPort0Able), 64'h0);
      chk("rst_p0_addr", 64'(WbPort0Addr), 64'h0);
      chk("rst_p1_data", 64'(WbPort1Date), 64'h0);

      // rotation: 0011 then 1100, pointer back at 0
      Rest = 1'b1;
      #1 chk("rot_c1_ready", 64'(ReqReady), 64'h3);
      cyc(); ReqValid = 4'b1100;
      #1 chk("rot_c2_ready", 64'(ReqReady), 64'hC);
      chk("rot_c1_p0", 64'(WbPort0Addr), 64'd40);
      chk("rot_c1_p1", 64'(WbPort1Addr), 64'd41);
      cyc(); ReqValid = 4'b1111;
      chk("rot_c2_p0", 64'(WbPort0Addr), 64'd42);
      chk("rot_c2_p1", 64'(WbPort1Addr), 64'd43);
      #1 chk("rot_ptr0", 64'(ReqReady), 64'h3);
      cyc(); ReqValid = 4'b1100;
      cyc(); ReqValid = 4'b0000;
      cyc();

      // address conflict: Div/Mul on 50, Csru on 51
      set_req(0, 7'd50, 32'h0000_D1D1);
      set_req(1, 7'd50, 32'h0000_A1A1);
      set_req(2, 7'd51, 32'h0000_C5C5);
      ReqValid = 4'b0111;
      #1 chk("conf_ready", 64'(ReqReady), 64'h5);
      cyc(); ReqValid = 4'b0010;
      #1 chk("conf_mul_ready", 64'(ReqReady), 64'h2);
      chk("conf_p0", 64'(WbPort0Date), 64'h0000_D1D1);
      chk("conf_p1", 64'(WbPort1Addr), 64'd51);
      cyc(); ReqValid = 4'b0000;
      chk("conf_mul_p0", 64'(WbPort0Date), 64'h0000_A1A1);
      chk("conf_mul_p1_able", 64'(WbPort1Able), 64'h0);

      // single request
      set_req(2, 7'd35, 32'hDEAD_BEEF);
      ReqValid = 4'b0100;
      #1 chk("single_ready", 64'(ReqReady), 64'h4);
      cyc(); ReqValid = 4'b0000;
      chk("single_able0", 64'(WbPort0Able), 64'h1);
      chk("single_addr0", 64'(WbPort0Addr), 64'd35);
      chk("single_data0", 64'(WbPort0Date), 64'hDEAD_BEEF);
      chk("single_able1", 64'(WbPort1Able), 64'h0);
      cyc();
      chk("single_drop", 64'(WbPort0Able), 64'h0);
      chk("single_hold", 64'(WbPort0Addr), 64'd35);

      // stall: grant, then three frozen cycles
      set_req(3, 7'd60, 32'h0600_0060);
      ReqValid = 4'b1000;
      #1 chk("stall_grant", 64'(ReqReady), 64'h8);
      cyc();
      set_req(1, 7'd61, 32'h0600_0061);
      ReqValid = 4'b0010;
      ArbStop  = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1 chk("stall_ready", 64'(ReqReady), 64'h0);
         chk("stall_able0", 64'(WbPort0Able), 64'h1);
         chk("stall_addr0", 64'(WbPort0Addr), 64'd60);
         chk("stall_data0", 64'(WbPort0Date), 64'h0600_0060);
         cyc();
      end
      chk("stall_frozen", 64'(WbPort0Addr), 64'd60);
      ArbStop = 1'b0;
      #1 chk("stall_release", 64'(ReqReady), 64'h2);
      cyc(); ReqValid = 4'b0000;
      chk("stall_after", 64'(WbPort0Addr), 64'd61);

      // flush over stall with a pending write
      set_req(2, 7'd70, 32'h0700_0070);
      ReqValid = 4'b0100;
      cyc();
      ReqValid = 4'b1000; ArbStop = 1'b1; ArbFlash = 1'b1;
      #1 chk("flush_ready", 64'(ReqReady), 64'h0);
      chk("flush_pending", 64'(WbPort0Able), 64'h1);
      cyc();
      ArbStop = 1'b0; ArbFlash = 1'b0;
      chk("flush_able0", 64'(WbPort0Able), 64'h0);
      chk("flush_able1", 64'(WbPort1Able), 64'h0);
      set_req(0, 7'd40, 32'h1000_0040);
      set_req(1, 7'd41, 32'h1000_0041);
      ReqValid = 4'b1111;
      #1 chk("flush_ptr0", 64'(ReqReady), 64'h3);
      cyc(); ReqValid = 4'b1100;
      cyc(); ReqValid = 4'b0000;
      cyc();

      // asynchronous reset while a write is presented
      set_req(0, 7'd80, 32'h0800_0080);
      ReqValid = 4'b0001;
      cyc(); ReqValid = 4'b0000;
      chk("arst_before", 64'(WbPort0Able), 64'h1);
      #2 Rest = 1'b0; ReqValid = 4'b0001;
      #1 chk("arst_able0", 64'(WbPort0Able), 64'h0);
      chk("arst_addr0", 64'(WbPort0Addr), 64'h0);
      chk("arst_ready", 64'(ReqReady), 64'h0);
      cyc();
      Rest = 1'b1;
      #1 chk("arst_represent", 64'(ReqReady), 64'h1);
      cyc(); ReqValid = 4'b0000;
      chk("arst_redo", 64'(WbPort0Addr), 64'd80);

      // short pseudo-random run with a narrow address set to force conflicts
      for (int n = 0; n < 40; n++) begin
         for (int r = 0; r < 4; r++) set_req(r, 7'(20 + $urandom_range(0, 3)), $urandom);
         ReqValid = 4'($urandom_range(0, 15));
         ArbStop  = ($urandom_range(0, 7) == 0);
         ArbFlash = ($urandom_range(0, 11) == 0);
         cyc();
      end
      ReqValid = 4'b0000; ArbStop = 1'b0; ArbFlash = 1'b0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
